volume_ramp_nch: RTL

//  NUM_CH-channel volume stage with per-sample gain ramping (no zipper noise), per-channel mute,

---
 rtl/volume_ramp_nch_pkg.sv | 43 ++++
 rtl/volume_ramp_nch_gain_ramp.sv | 80 ++++++++
 rtl/volume_ramp_nch.sv | 116 +++++++++++
 3 files changed

// File: rtl/volume_ramp_nch_pkg.sv
// Shared types, constants and helpers for the multi-channel volume stage.
//
// Contents:
//   SAMPLE_W_DEF / VOLUME_BITS_DEF  default sample width and volume index width
//   sample_t                        signed audio sample at the default width
//   gain_t                          unsigned gain (VOLUME_BITS+1 bits) at the default width
//   GAIN_UNITY                      gain value that passes samples through unchanged
//   ramp_dir_e                      direction of the gain ramp for one channel
//   sat_sample()                    clamps a wide signed value to a w-bit signed range
package volume_ramp_nch_pkg;

    localparam int unsigned SAMPLE_W_DEF    = 16;
    localparam int unsigned VOLUME_BITS_DEF = 8;

    typedef logic signed [SAMPLE_W_DEF-1:0] sample_t;
    typedef logic        [VOLUME_BITS_DEF:0] gain_t;

    localparam gain_t GAIN_UNITY = gain_t'(2 ** VOLUME_BITS_DEF);

    typedef enum logic [1:0] {
        RAMP_HOLD,
        RAMP_UP,
        RAMP_DOWN
    } ramp_dir_e;

    // Result is returned at full width so callers of any sample width can
    // truncate it; the value always fits in w signed bits.
    function automatic logic signed [63:0] sat_sample(input logic signed [63:0] x,
                                                      input int unsigned        w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/volume_ramp_nch_gain_ramp.sv
// Per-channel gain ramp generator.
//
// Maps the requested volume/mute onto a target gain and walks the applied gain
// towards it by at most RAMP_STEP per accepted sample, never overshooting.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset (gain returns to 0)
//   adv        in   a sample is accepted this cycle; the gain may move
//   volume     in   VOLUME_BITS volume index; all-ones selects exact unity
//   mute       in   forces the target to 0
//   gain_cur   out  VOLUME_BITS+1 gain currently applied to samples
//   ramp_busy  out  gain_cur differs from the present target
module volume_ramp_nch_gain_ramp
    import volume_ramp_nch_pkg::*;
#(
    parameter int unsigned VOLUME_BITS = VOLUME_BITS_DEF,
    parameter int unsigned RAMP_STEP   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   adv,
    input  logic [VOLUME_BITS-1:0] volume,
    input  logic                   mute,
    output logic [VOLUME_BITS:0]   gain_cur,
    output logic                   ramp_busy
);

    localparam int unsigned GW = VOLUME_BITS + 1;
    localparam logic [GW-1:0] STEP  = GW'(RAMP_STEP);
    localparam logic [GW-1:0] UNITY = GW'(2 ** VOLUME_BITS);

    logic [GW-1:0] tgt;
    logic [GW-1:0] diff;
    logic [GW-1:0] gain_q;
    logic [GW-1:0] gain_d;
    ramp_dir_e     dir;

    always_comb begin
        tgt = mute ? '0 : ((&volume) ? UNITY : {1'b0, volume});

        if (gain_q < tgt) begin
            dir = RAMP_UP;
        end else if (gain_q > tgt) begin
            dir = RAMP_DOWN;
        end else begin
            dir = RAMP_HOLD;
        end

        // Compare the remaining distance against the step instead of adding
        // first, so gain_q + STEP is only formed when it cannot wrap.
        diff   = '0;
        gain_d = gain_q;
        case (dir)
            RAMP_UP: begin
                diff   = tgt - gain_q;
                gain_d = (diff > STEP) ? gain_q + STEP : tgt;
            end
            RAMP_DOWN: begin
                diff   = gain_q - tgt;
                gain_d = (diff > STEP) ? gain_q - STEP : tgt;
            end
            default: begin
                gain_d = gain_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gain_q <= '0;
        end else if (adv) begin
            gain_q <= gain_d;
        end
    end

    assign gain_cur  = gain_q;
    assign ramp_busy = (gain_q != tgt);

endmodule

// File: rtl/volume_ramp_nch.sv
// NUM_CH-channel volume stage with per-sample gain ramping, per-channel mute,
// round-half-up scaling, exact unity gain and output saturation.
// Two-stage pipeline (multiply, then round/clamp), latency 2, no backpressure.
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset; drops in-flight samples
//   in_valid    in   sample_in carries one sample per channel this cycle
//   sample_in   in   NUM_CH*SAMPLE_W signed samples, ch0 in the LSBs
//   volume      in   NUM_CH*VOLUME_BITS per-channel target volume index
//   mute        in   NUM_CH per-channel mute request (ramps to 0)
//   out_valid   out  sample_out updated this cycle (in_valid delayed by 2)
//   sample_out  out  NUM_CH*SAMPLE_W scaled samples, held while out_valid=0
//   gain_cur    out  NUM_CH*(VOLUME_BITS+1) gain currently applied per channel
//   ramp_busy   out  NUM_CH flags, gain_cur differs from target
module volume_ramp_nch
    import volume_ramp_nch_pkg::*;
#(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned SAMPLE_W    = SAMPLE_W_DEF,
    parameter int unsigned VOLUME_BITS = VOLUME_BITS_DEF,
    parameter int unsigned RAMP_STEP   = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0]       sample_in,
    input  logic [NUM_CH*VOLUME_BITS-1:0]    volume,
    input  logic [NUM_CH-1:0]                mute,
    output logic                             out_valid,
    output logic [NUM_CH*SAMPLE_W-1:0]       sample_out,
    output logic [NUM_CH*(VOLUME_BITS+1)-1:0] gain_cur,
    output logic [NUM_CH-1:0]                ramp_busy
);

    localparam int unsigned GW = VOLUME_BITS + 1;
    localparam int unsigned PW = SAMPLE_W + VOLUME_BITS + 2;
    localparam logic signed [PW-1:0] RND = PW'(2 ** (VOLUME_BITS - 1));

    logic v1_q;
    logic ov_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            ov_q <= 1'b0;
        end else begin
            v1_q <= in_valid;
            ov_q <= v1_q;
        end
    end

    assign out_valid = ov_q;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [GW-1:0]             gain;
        logic                      busy;
        logic signed [SAMPLE_W-1:0] samp;
        logic signed [GW:0]        gain_s;
        logic signed [PW-1:0]      prod_d;
        logic signed [PW-1:0]      prod_q;
        logic signed [PW-1:0]      sum;
        logic signed [PW-1:0]      rnd_sh;
        logic signed [SAMPLE_W-1:0] samp_d;
        logic signed [SAMPLE_W-1:0] samp_q;

        volume_ramp_nch_gain_ramp #(
            .VOLUME_BITS(VOLUME_BITS),
            .RAMP_STEP  (RAMP_STEP)
        ) u_ramp (
            .clk      (clk),
            .rst      (rst),
            .adv      (in_valid),
            .volume   (volume[ch*VOLUME_BITS +: VOLUME_BITS]),
            .mute     (mute[ch]),
            .gain_cur (gain),
            .ramp_busy(busy)
        );

        // Stage 1: the sample is scaled by the gain in effect before this
        // edge's ramp update; gain is zero-extended so it stays positive.
        always_comb begin
            samp   = sample_in[ch*SAMPLE_W +: SAMPLE_W];
            gain_s = {1'b0, gain};
            prod_d = PW'(samp) * PW'(gain_s);
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                prod_q <= '0;
            end else if (in_valid) begin
                prod_q <= prod_d;
            end
        end

        // Stage 2: round half up, arithmetic shift, then clamp to the sample range.
        always_comb begin
            sum    = prod_q + RND;
            rnd_sh = sum >>> VOLUME_BITS;
            samp_d = SAMPLE_W'(sat_sample(64'(rnd_sh), SAMPLE_W));
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                samp_q <= '0;
            end else if (v1_q) begin
                samp_q <= samp_d;
            end
        end

        assign sample_out[ch*SAMPLE_W +: SAMPLE_W] = samp_q;
        assign gain_cur[ch*GW +: GW]               = gain;
        assign ramp_busy[ch]                       = busy;
    end

endmodule
